delay_axis: RTL and testbench
=============================

Name: delay_axis

Overview:
- Stereo audio delay line with an AXI4-Stream sample path and an AXI4-Lite control port.
- Each 32-bit stream beat carries one stereo sample: left in bits [15:0], right in bits [31:16].
- Each channel is delayed by an independent, software-programmed number of samples, using a circular buffer of 2^DELAY_ADDR_W entries per channel.
- The block sits inline between an audio source and a sink (e.g. I2S/DMA) in the audio pipeline.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: AXI-Lite data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: AXI-Lite byte-address width.
- AUDIO_WIDTH, 16: bits per channel sample, signed. Stream width is 2*AUDIO_WIDTH.
- DELAY_ADDR_W, 12: log2 of the buffer depth per channel. Maximum delay is 2^DELAY_ADDR_W-1 samples (4095 at the default).

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  reset, asynchronous and active-low.
- s_axis_tdata  in  32  input sample, {R,L}.
- s_axis_tlast  in  1  input frame marker.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  32  output sample, {R,L}.
- m_axis_tlast  out  1  output frame marker.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- s_axi_awaddr  in  4;  s_axi_awvalid  in  1;  s_axi_awready  out  1.
- s_axi_wdata  in  32;  s_axi_wstrb  in  4;  s_axi_wvalid  in  1;  s_axi_wready  out  1.
- s_axi_bresp  out  2;  s_axi_bvalid  out  1;  s_axi_bready  in  1.
- s_axi_araddr  in  4;  s_axi_arvalid  in  1;  s_axi_arready  out  1.
- s_axi_rdata  out  32;  s_axi_rresp  out  2;  s_axi_rvalid  out  1;  s_axi_rready  in  1.

Behaviour:
- Reset: all outputs 0, except s_axis_tready, which is 1 after reset deasserts. All registers cleared; write pointer and fill counters cleared. Buffer RAM is not cleared.
- Register map:
  - 0x0 CTRL: bit0 ENABLE, reset 0.
  - 0x4 DELAY_L: low DELAY_ADDR_W bits, reset 0.
  - 0x8 DELAY_R: low DELAY_ADDR_W bits, reset 0.
  - All registers read back as written (unused bits read 0). Other addresses read 0; writes to them are ignored.
- AXI-Lite write:
  - awready and wready pulse high together for one cycle when awvalid && wvalid && !bvalid.
  - wstrb is honoured per byte.
  - bvalid is set on the next cycle and held until bready; bresp = 00.
- AXI-Lite read:
  - arready pulses for one cycle when arvalid && !rvalid.
  - rdata is registered; rvalid is held until rready; rresp = 00.
- Stream handshake:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready, giving a single output register stage.
  - A sample is accepted when s_axis_tvalid && s_axis_tready.
  - On acceptance, the output register loads on the same edge, so m_axis_tvalid rises 1 cycle after acceptance.
  - While m_axis_tvalid && !m_axis_tready, the output data is held stable.
  - m_axis_tlast is the registered s_axis_tlast.
- Delay, per channel with delay D:
  - On acceptance, the input sample is written at wr_ptr and wr_ptr increments modulo 2^DELAY_ADDR_W.
  - The output is buffer[wr_ptr - D] (modulo), i.e. the input sample accepted D samples earlier.
  - D = 0 forwards the current input directly, bypassing the RAM read-during-write.
  - A saturating fill counter counts accepted samples since reset. While fill < D, the channel outputs 0, so stale RAM is never emitted.
- ENABLE = 0: samples are still written to the buffer and the pointer still advances, but the output equals the current input (pass-through, 1-cycle latency).
- Changing ENABLE or DELAY takes effect on the next accepted sample. The buffer is not flushed. Gaps in s_axis_tvalid do not advance the delay.
- Arithmetic: all buffer indexing is pure modulo 2^DELAY_ADDR_W. No sample arithmetic is performed; samples pass bit-exact.
- Reset mid-stream: the output is dropped immediately (tvalid = 0), pointers and fill counters return to 0, and the first D outputs after reset are 0.

Optional Feature:
- Macro DELAY_AXIS_STATUS_EN.
- Defined: adds read-only register 0xC = 32-bit count of accepted stream samples since reset, wrapping. Writes to 0xC are ignored.
- Undefined: 0xC reads 0 and no counter logic is generated.

Test Plan:
- Reset: hold aresetn low for 10 cycles, then release → all AXI outputs 0, s_axis_tready = 1, registers 0x0/0x4/0x8 read back 0.
- Configuration: write 0x4 = 50, 0x8 = 100, 0x0 = 1 → each write gets bresp = 00; readback returns 50 / 100 / 1.
- Stereo delay:
  - Stimulus: stream 500 samples with L = round(30000·sin(2πi/50)) and R = round(30000·sin(2πi/100)), then 150 zero samples, m_axis_tready = 1.
  - Required: output k has L = in_L[k-50] and R = in_R[k-100]. Outputs 0..49 (L) and 0..99 (R) are 0. The final zeros appear 50 / 100 samples after the input zeros begin.
- Bypass: ENABLE = 0, stream 8 ramp samples → output = input, each one cycle later.
- Backpressure: toggle m_axis_tready 1/0 every cycle with D_L = 3 → no sample lost or duplicated; s_axis_tready low exactly while the output is stalled; data held stable while stalled.
- Boundary:
  - D_L = 0 → output equals the same-sample input.
  - D_L = 4095 → the first nonzero output appears at accepted sample 4095.
  - Stream 5000 samples → delay correct across pointer wrap.

Source files
------------

// File: rtl/delay_axis.sv
`default_nettype none
// ============================================================================
// Module   : delay_axis
// Purpose  : Stereo audio delay line. Each 32-bit AXI4-Stream beat carries
//            {R,L} signed samples; each channel is delayed by its own
//            software-programmed number of samples using a circular buffer
//            of 2^DELAY_ADDR_W entries per channel. AXI4-Lite control port.
// Ports    : aclk, aresetn (async, active-low)
//            s_axis_*  : input sample stream  {R,L}
//            m_axis_*  : output sample stream {R,L}, single register stage
//            s_axi_*   : AXI4-Lite slave, map 0x0 CTRL, 0x4 DELAY_L,
//                        0x8 DELAY_R, 0xC sample count (optional)
// Options  : `define DELAY_AXIS_STATUS_EN adds the read-only 32-bit accepted
//            sample counter at 0xC; otherwise 0xC reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module delay_axis #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int AUDIO_WIDTH        = 16,
  parameter int DELAY_ADDR_W       = 12
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [2*AUDIO_WIDTH-1:0]          s_axis_tdata,
  input  logic                              s_axis_tlast,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [2*AUDIO_WIDTH-1:0]          m_axis_tdata,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready
);

  localparam int c_DEPTH = 1 << DELAY_ADDR_W;
  localparam logic [DELAY_ADDR_W-1:0]       c_PTR_ONE      = DELAY_ADDR_W'(1);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] c_ADDR_CTRL    = C_S_AXI_ADDR_WIDTH'(0);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] c_ADDR_DELAY_L = C_S_AXI_ADDR_WIDTH'(4);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] c_ADDR_DELAY_R = C_S_AXI_ADDR_WIDTH'(8);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] c_ADDR_STATUS  = C_S_AXI_ADDR_WIDTH'(12);

  // --------------------------------------------------------------------------
  // AXI4-Lite control registers
  // --------------------------------------------------------------------------
  logic                          r_enable;
  logic [DELAY_ADDR_W-1:0]       r_delay_l;
  logic [DELAY_ADDR_W-1:0]       r_delay_r;
  logic                          r_awready;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_wmask;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rdata;
  logic                          w_wr_en;
  logic                          w_rd_en;
  logic                          w_accept;

  generate
    for (genvar gi = 0; gi < C_S_AXI_DATA_WIDTH/8; gi++) begin : g_strb
      assign w_wmask[gi*8 +: 8] = {8{s_axi_wstrb[gi]}};
    end
  endgenerate

  // awready is a one-cycle pulse; the write itself lands while it is high.
  assign w_wr_en = r_awready && s_axi_awvalid && s_axi_wvalid;
  assign w_rd_en = r_arready && s_axi_arvalid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_enable  <= 1'b0;
      r_delay_l <= '0;
      r_delay_r <= '0;
    end else begin
      r_awready <= !r_awready && s_axi_awvalid && s_axi_wvalid && !r_bvalid;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        case (s_axi_awaddr)
          c_ADDR_CTRL:    if (s_axi_wstrb[0]) r_enable <= s_axi_wdata[0];
          c_ADDR_DELAY_L: r_delay_l <= (r_delay_l & ~w_wmask[DELAY_ADDR_W-1:0]) |
                                       (s_axi_wdata[DELAY_ADDR_W-1:0] & w_wmask[DELAY_ADDR_W-1:0]);
          c_ADDR_DELAY_R: r_delay_r <= (r_delay_r & ~w_wmask[DELAY_ADDR_W-1:0]) |
                                       (s_axi_wdata[DELAY_ADDR_W-1:0] & w_wmask[DELAY_ADDR_W-1:0]);
          default: ;
        endcase
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

`ifdef DELAY_AXIS_STATUS_EN
  logic [C_S_AXI_DATA_WIDTH-1:0] r_sample_count;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)      r_sample_count <= '0;
    else if (w_accept) r_sample_count <= r_sample_count + C_S_AXI_DATA_WIDTH'(1);
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (s_axi_araddr)
      c_ADDR_CTRL:    w_rdata[0] = r_enable;
      c_ADDR_DELAY_L: w_rdata[DELAY_ADDR_W-1:0] = r_delay_l;
      c_ADDR_DELAY_R: w_rdata[DELAY_ADDR_W-1:0] = r_delay_r;
`ifdef DELAY_AXIS_STATUS_EN
      c_ADDR_STATUS:  w_rdata = r_sample_count;
`else
      c_ADDR_STATUS:  w_rdata = '0;
`endif
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= !r_arready && s_axi_arvalid && !r_rvalid;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (r_rvalid && s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Upper data/strobe bits have no storage behind them.
  logic w_unused_bits;
  assign w_unused_bits = ^{s_axi_wdata, w_wmask};

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_awready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;

  // --------------------------------------------------------------------------
  // Delay datapath
  // --------------------------------------------------------------------------
  logic [AUDIO_WIDTH-1:0]   r_mem_l [0:c_DEPTH-1];
  logic [AUDIO_WIDTH-1:0]   r_mem_r [0:c_DEPTH-1];
  logic [DELAY_ADDR_W-1:0]  r_wr_ptr;
  logic [DELAY_ADDR_W-1:0]  r_fill;
  logic [2*AUDIO_WIDTH-1:0] r_m_tdata;
  logic                     r_m_tlast;
  logic                     r_m_tvalid;
  logic [AUDIO_WIDTH-1:0]   w_in_l;
  logic [AUDIO_WIDTH-1:0]   w_in_r;
  logic [AUDIO_WIDTH-1:0]   w_out_l;
  logic [AUDIO_WIDTH-1:0]   w_out_r;
  logic [DELAY_ADDR_W-1:0]  w_rd_addr_l;
  logic [DELAY_ADDR_W-1:0]  w_rd_addr_r;

  assign s_axis_tready = !r_m_tvalid || m_axis_tready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_in_l        = s_axis_tdata[AUDIO_WIDTH-1:0];
  assign w_in_r        = s_axis_tdata[2*AUDIO_WIDTH-1:AUDIO_WIDTH];
  assign w_rd_addr_l   = r_wr_ptr - r_delay_l;
  assign w_rd_addr_r   = r_wr_ptr - r_delay_r;

  // Buffer RAM has no reset; the fill counter masks stale contents.
  always_ff @(posedge aclk) begin
    if (w_accept) begin
      r_mem_l[r_wr_ptr] <= w_in_l;
      r_mem_r[r_wr_ptr] <= w_in_r;
    end
  end

  // The RAM is read combinationally so the output register loads on the
  // acceptance edge. Delay 0 would read the slot being written, so it takes
  // the input directly. One fill counter serves both channels: both count
  // the same accepted samples.
  always_comb begin
    w_out_l = w_in_l;
    w_out_r = w_in_r;
    if (r_enable && (r_delay_l != '0))
      w_out_l = (r_fill < r_delay_l) ? '0 : r_mem_l[w_rd_addr_l];
    if (r_enable && (r_delay_r != '0))
      w_out_r = (r_fill < r_delay_r) ? '0 : r_mem_r[w_rd_addr_r];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
        if (r_fill != '1) r_fill <= r_fill + c_PTR_ONE;
        r_m_tdata  <= {w_out_r, w_out_l};
        r_m_tlast  <= s_axis_tlast;
        r_m_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tvalid = r_m_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_delay_axis.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_axis
// Purpose  : Self-checking bench for delay_axis. A history-based reference
//            model predicts every output beat at input acceptance and pushes
//            it to a scoreboard queue; an output monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_axis;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [3:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  always #5 aclk = ~aclk;

  delay_axis #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4),
    .AUDIO_WIDTH(16), .DELAY_ADDR_W(12)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready)
  );

  typedef struct packed { logic last; logic [31:0] data; } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  logic [15:0] hist_l[$];
  logic [15:0] hist_r[$];
  int          m_en = 0, m_dl = 0, m_dr = 0;
  int          n_acc = 0, n_out = 0, first_nz_l = -1;
  int          ready_mode = 0;  // 0 always, 1 toggle, 2 random, 3 held low
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output-ready pattern generator.
  always @(posedge aclk) begin
    #1;
    case (ready_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ~m_axis_tready;
      2: m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Input monitor + reference model: output k = input k-D, 0 before D samples.
  always @(negedge aclk) begin
    if (aresetn && s_axis_tvalid && s_axis_tready) begin
      logic [15:0] il, ir, el, er;
      int k;
      il = s_axis_tdata[15:0];
      ir = s_axis_tdata[31:16];
      k  = hist_l.size();
      if (m_en == 0 || m_dl == 0) el = il;
      else if (k < m_dl)          el = 16'h0;
      else                        el = hist_l[k - m_dl];
      if (m_en == 0 || m_dr == 0) er = ir;
      else if (k < m_dr)          er = 16'h0;
      else                        er = hist_r[k - m_dr];
      hist_l.push_back(il);
      hist_r.push_back(ir);
      exp_q.push_back('{last: s_axis_tlast, data: {er, el}});
      n_acc++;
    end
  end

  // Output monitor: scoreboard pop, stall stability, ready relationship.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      exp_t e;
      if (prev_stall) begin
        check("stall_valid_held", m_axis_tvalid, 1);
        check("stall_data_held", {m_axis_tlast, m_axis_tdata}, prev_word);
      end
      check("s_tready_vs_stall", s_axis_tready, !(m_axis_tvalid && !m_axis_tready));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, expected no beat", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_axis_tdata, e.data);
          check("out_last", m_axis_tlast, e.last);
        end
        if (m_axis_tdata[15:0] != 16'h0 && first_nz_l < 0) first_nz_l = n_out;
        n_out++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tlast, m_axis_tdata};
    end
  end

  // All tasks below start and end at posedge+1.
  task automatic do_reset();
    s_axis_tvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    aresetn = 1'b0;
    #1 check("reset_drops_tvalid", m_axis_tvalid, 0);
    hist_l.delete(); hist_r.delete(); exp_q.delete();
    m_en = 0; m_dl = 0; m_dr = 0; n_acc = 0; n_out = 0; first_nz_l = -1;
    repeat (10) @(posedge aclk);
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r, input logic last);
    int   t = 0;
    logic ok = 1'b0;
    s_axis_tdata = {r, l}; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    while (!ok && t < 1000) begin
      @(negedge aclk); ok = s_axis_tready;
      @(posedge aclk); #1; t++;
    end
    s_axis_tvalid = 1'b0;
    if (!ok) begin n_checks++; n_fail++; $display("FAIL send_timeout: got no s_axis_tready, expected acceptance"); end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int   t = 0;
    logic done = 1'b0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    while (!done && t < 100) begin
      @(negedge aclk);
      if (s_axi_awready) begin check("wready_with_awready", s_axi_wready, 1); done = 1'b1; end
      @(posedge aclk); #1; t++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    if (!done) begin n_checks++; n_fail++; $display("FAIL aw_timeout: got no awready, expected handshake"); end
    s_axi_bready = 1'b1; done = 1'b0; t = 0;
    while (!done && t < 100) begin
      @(negedge aclk);
      if (s_axi_bvalid) begin check("bresp", s_axi_bresp, 0); done = 1'b1; end
      @(posedge aclk); #1; t++;
    end
    s_axi_bready = 1'b0;
    if (!done) begin n_checks++; n_fail++; $display("FAIL b_timeout: got no bvalid, expected response"); end
  endtask

  task automatic axi_read_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
    int   t = 0;
    logic done = 1'b0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    while (!done && t < 100) begin
      @(negedge aclk); done = s_axi_arready;
      @(posedge aclk); #1; t++;
    end
    s_axi_arvalid = 1'b0;
    if (!done) begin n_checks++; n_fail++; $display("FAIL ar_timeout: got no arready, expected handshake"); end
    s_axi_rready = 1'b1; done = 1'b0; t = 0;
    while (!done && t < 100) begin
      @(negedge aclk);
      if (s_axi_rvalid) begin check(name, s_axi_rdata, exp); check("rresp", s_axi_rresp, 0); done = 1'b1; end
      @(posedge aclk); #1; t++;
    end
    s_axi_rready = 1'b0;
    if (!done) begin n_checks++; n_fail++; $display("FAIL r_timeout: got no rvalid, expected read data"); end
  endtask

  task automatic configure(input int en, input int dl, input int dr);
    axi_write(4'h4, 32'(dl), 4'hF); m_dl = dl;
    axi_write(4'h8, 32'(dr), 4'hF); m_dr = dr;
    axi_write(4'h0, 32'(en), 4'hF); m_en = en;
  endtask

  task automatic drain();
    int t = 0;
    ready_mode = (ready_mode == 3) ? 0 : ready_mode;
    while (exp_q.size() > 0 && t < 5000) begin @(posedge aclk); #1; t++; end
    check("drain_empty", exp_q.size(), 0);
    check("no_loss_or_dup", n_out, hist_l.size());
  endtask

  function automatic logic [15:0] sine(input int i, input int period);
    real v;
    int  r;
    v = 30000.0 * $sin(2.0 * 3.14159265358979 * i / period);
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    return r[15:0];
  endfunction

  function automatic logic [31:0] status_exp();
`ifdef DELAY_AXIS_STATUS_EN
    return 32'(n_acc);
`else
    return 32'h0;
`endif
  endfunction

  initial begin
    @(posedge aclk); #1;

    // Reset state and register defaults.
    do_reset();
    check("reset_axi_outs", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                             s_axi_arready, s_axi_rvalid, s_axi_rresp}, 0);
    check("reset_rdata", s_axi_rdata, 0);
    check("reset_m_axis", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 0);
    check("reset_s_tready", s_axis_tready, 1);
    axi_read_check("rd_ctrl_reset", 4'h0, 0);
    axi_read_check("rd_dl_reset", 4'h4, 0);
    axi_read_check("rd_dr_reset", 4'h8, 0);
    axi_read_check("rd_status_reset", 4'hC, 0);

    // Configuration and stereo sine delay.
    configure(1, 50, 100);
    axi_read_check("rd_dl_50", 4'h4, 50);
    axi_read_check("rd_dr_100", 4'h8, 100);
    axi_read_check("rd_ctrl_1", 4'h0, 1);
    for (int i = 0; i < 500; i++) send(sine(i, 50), sine(i, 100), (i % 50) == 49);
    for (int i = 0; i < 150; i++) send(16'h0, 16'h0, 1'b0);
    drain();
    axi_read_check("rd_status_count", 4'hC, status_exp());

    // Bypass: one-cycle latency, output equals input.
    axi_write(4'h0, 32'h0, 4'hF); m_en = 0;
    for (int i = 0; i < 8; i++) begin
      send(16'(16'h0100 + i), 16'(16'h8000 + i), 1'b0);
      @(negedge aclk);
      check("bypass_valid_next", m_axis_tvalid, 1);
      check("bypass_data", m_axis_tdata, {16'(16'h8000 + i), 16'(16'h0100 + i)});
      @(posedge aclk); #1;
    end
    drain();

    // D_L = 0 with random gaps and random output ready.
    configure(1, 0, 7);
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    end
    drain();

    // Backpressure: output ready toggles every cycle.
    configure(1, 3, 2);
    ready_mode = 1;
    for (int i = 0; i < 60; i++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    drain();
    ready_mode = 0;

    // Byte strobes, unused bits, ignored address.
    axi_write(4'h4, 32'h0000_0FFF, 4'hF);
    axi_write(4'h4, 32'h1234_5A5A, 4'h1);
    axi_read_check("strb_byte0", 4'h4, 32'h0000_0F5A);
    axi_write(4'h4, 32'hFFFF_F3FF, 4'h2);
    axi_read_check("strb_byte1", 4'h4, 32'h0000_035A);
    axi_write(4'h0, 32'hFFFF_FFFF, 4'hF);
    axi_read_check("ctrl_unused_bits", 4'h0, 1);
    axi_write(4'hC, 32'hDEAD_BEEF, 4'hF);
    axi_read_check("status_write_ignored", 4'hC, status_exp());
    axi_read_check("dr_untouched", 4'h8, 2);

    // Reset while the output is stalled, then maximum delay across wrap.
    ready_mode = 3;
    @(posedge aclk); #1;
    send(16'h1111, 16'h2222, 1'b0);
    do_reset();
    ready_mode = 2;
    begin
      int dr;
      dr = $urandom_range(1, 4095);
      configure(1, 4095, dr);
    end
    for (int i = 0; i < 5000; i++) begin
      send(16'($urandom) | 16'h1, 16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
    end
    drain();
    check("first_nonzero_at_4095", first_nz_l, 4095);
    axi_read_check("rd_status_wrap", 4'hC, status_exp());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
